// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-side signals around uart_tx_arbiter.
// The arbiter connects through the slave modport; clients and the UART use master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0] req_parity;
    logic [2*NUM_REQ-1:0] req_baud;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   nack;
    logic                 busy;
    logic                 send;
    logic [7:0]           data_in;
    logic [1:0]           parity_type;
    logic [1:0]           baud_rate;
    logic                 tx_active_flag;
    logic                 tx_done_flag;

    modport master (
        output req, req_data, req_parity, req_baud, tx_active_flag, tx_done_flag,
        input  grant, ack, nack, busy, send, data_in, parity_type, baud_rate
    );

    modport slave (
        input  req, req_data, req_parity, req_baud, tx_active_flag, tx_done_flag,
        output grant, ack, nack, busy, send, data_in, parity_type, baud_rate
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional send timeout with nack is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 262143
) (
    input  logic               clock,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 262143) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] req_q;
    logic               done_q, done_qq;
    logic               done_rise;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   winner;
    logic               winner_valid;
    logic               take;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] last_oh;
    logic [7:0]         data_q;
    logic [1:0]         parity_q;
    logic [1:0]         baud_q;

    // Requests and done flag are registered; the done edge is found between
    // two registered copies, so a level left high by an earlier frame is inert.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            done_q  <= 1'b0;
            done_qq <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            req_q   <= bus.req;
            done_q  <= bus.tx_done_flag;
            done_qq <= done_q;
        end
    end

    assign done_rise = done_q & ~done_qq;

    // Search starts just after the last winner; scanning downwards lets the
    // nearest set request overwrite farther ones.
    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        winner       = '0;
        winner_valid = 1'b0;
        cand         = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req_q[cand]) begin
                winner       = cand;
                winner_valid = 1'b1;
            end
        end
    end

    assign take = (state == IDLE) && winner_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (winner_valid) state_next = START;
            START: begin
                if (tmo_hit)                 state_next = RELEASE;
                else if (bus.tx_active_flag) state_next = WAIT_DONE;
            end
            WAIT_DONE: if (done_rise || tmo_hit) state_next = RELEASE;
            RELEASE:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Winner fields are captured once per grant and held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last     <= IDX_W'(NUM_REQ - 1);
            data_q   <= 8'h00;
            parity_q <= 2'b00;
            baud_q   <= 2'b00;
        end else if (take) begin
            last     <= winner;
            data_q   <= bus.req_data[8*int'(winner) +: 8];
            parity_q <= bus.req_parity[2*int'(winner) +: 2];
            baud_q   <= bus.req_baud[2*int'(winner) +: 2];
        end
    end

    assign last_oh = NUM_REQ'(1) << last;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [17:0] TMO_LIMIT = 18'(TIMEOUT_CYCLES);

    logic [17:0] tmo_cnt;
    logic        timed_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (take) begin
            tmo_cnt <= '0;
        end else if (state == START || state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 18'd1;
        end
    end

    assign tmo_hit = (state == START || state == WAIT_DONE) && (tmo_cnt == TMO_LIMIT);

    // A completion seen in the same cycle as the limit still counts as success.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timed_out <= 1'b0;
        end else if (state != RELEASE) begin
            timed_out <= tmo_hit && !(state == WAIT_DONE && done_rise);
        end
    end

    assign bus.ack  = (state == RELEASE && !timed_out) ? last_oh : '0;
    assign bus.nack = (state == RELEASE &&  timed_out) ? last_oh : '0;
`else
    assign tmo_hit  = 1'b0;
    assign bus.ack  = (state == RELEASE) ? last_oh : '0;
    assign bus.nack = '0;
`endif

    assign bus.grant       = (state == START || state == WAIT_DONE) ? last_oh : '0;
    assign bus.busy        = (state != IDLE);
    assign bus.send        = (state == START);
    assign bus.data_in     = data_q;
    assign bus.parity_type = parity_q;
    assign bus.baud_rate   = baud_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a list-level round-robin model predicts
// the grant sequence; a monitor checks each frame against the predicted queue.
module tb_uart_tx_arbiter;
    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 262143;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [1:0] par;
        logic [1:0] baud;
        bit         timeout;
    } job_t;

    job_t job_q[N][$];
    job_t exp_q[$];
    job_t cur;
    bit   cur_valid;
    int   n_total, n_pass;
    int   done_count, expected_done;
    int   ref_last = N - 1;
    int   uart_act_delay, uart_frame_len;
    bit   model_en, model_abort;
    int   frames_done, frames_at_send, send_cycles;
    bit   send_prev, after_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic load_req(input int i);
        if (job_q[i].size() > 0) begin
            bus.req[i]              = 1'b1;
            bus.req_data[8*i +: 8]  = job_q[i][0].data;
            bus.req_parity[2*i +: 2] = job_q[i][0].par;
            bus.req_baud[2*i +: 2]  = job_q[i][0].baud;
        end else begin
            bus.req[i] = 1'b0;
        end
    endtask

    task automatic add_job(input int i, input logic [7:0] d, input logic [1:0] p,
                           input logic [1:0] b, input bit to);
        job_t j;
        j.idx = i; j.data = d; j.par = p; j.baud = b; j.timeout = to;
        job_q[i].push_back(j);
    endtask

    // Reference: every pending job is served, each time picking the first
    // requester after the previous winner that still has work.
    task automatic schedule();
        int used[N];
        int left = 0;
        for (int i = 0; i < N; i++) begin
            used[i] = 0;
            left += job_q[i].size();
        end
        expected_done += left;
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                int j = (ref_last + k) % N;
                if (used[j] < job_q[j].size()) begin
                    exp_q.push_back(job_q[j][used[j]]);
                    used[j]++;
                    ref_last = j;
                    left--;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) load_req(i);
    endtask

    task automatic wait_all(input int budget);
        int c = 0;
        while (done_count < expected_done && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("batch_complete", done_count, expected_done);
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    // Requesters: advance to the next job on completion, and scribble over
    // their own inputs while granted to expose any unlatched field.
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i] || bus.nack[i]) begin
                    if (job_q[i].size() > 0) void'(job_q[i].pop_front());
                    load_req(i);
                end else if (bus.grant[i] && job_q[i].size() > 0) begin
                    bus.req_data[8*i +: 8]  = job_q[i][0].data ^ 8'(1 + $urandom_range(254));
                    bus.req_baud[2*i +: 2]  = ~job_q[i][0].baud;
                end
            end
        end
    end

    // UART model: active after uart_act_delay cycles of send, done after
    // uart_frame_len more; done stays high until the next frame starts.
    initial forever begin
        @(negedge clock);
        if (model_en && reset_n && !model_abort && bus.send) begin
            for (int c = 1; c < uart_act_delay && !model_abort; c++) @(negedge clock);
            if (!model_abort) begin
                bus.tx_active_flag = 1'b1;
                bus.tx_done_flag   = 1'b0;
            end
            for (int c = 0; c < uart_frame_len && !model_abort; c++) @(negedge clock);
            bus.tx_active_flag = 1'b0;
            if (!model_abort) begin
                bus.tx_done_flag = 1'b1;
                frames_done++;
            end
        end
    end

    // Monitor: pop the prediction on each send, compare on each ack/nack.
    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            cur_valid = 1'b0;
            send_prev = 1'b0;
            after_ack = 1'b0;
        end else begin
            if (after_ack) begin
                check("busy_after_ack", bus.busy, 0);
                check("ack_one_cycle", {bus.ack, bus.nack}, 0);
                after_ack = 1'b0;
            end
            if (bus.send && !send_prev) begin
                check("send_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur            = exp_q.pop_front();
                    cur_valid      = 1'b1;
                    send_cycles    = 0;
                    frames_at_send = frames_done;
                    check("grant", bus.grant, oh(cur.idx));
                    check("data_in", bus.data_in, cur.data);
                    check("parity_type", bus.parity_type, cur.par);
                    check("baud_rate", bus.baud_rate, cur.baud);
                end
            end
            if (bus.send) send_cycles++;
            if (bus.ack != 0 || bus.nack != 0) begin
                check("completion_expected", cur_valid, 1);
                if (cur_valid) begin
                    check("ack", bus.ack, cur.timeout ? N'(0) : oh(cur.idx));
                    check("nack", bus.nack, cur.timeout ? oh(cur.idx) : N'(0));
                    check("data_stable", bus.data_in, cur.data);
                    check("grant_released", bus.grant, 0);
                    if (cur.timeout) begin
                        check("timeout_window", send_cycles >= TMO && send_cycles <= TMO + 2, 1);
                    end else begin
                        check("send_len", send_cycles, uart_act_delay);
                        check("done_edge", frames_done, frames_at_send + 1);
                    end
                    cur_valid = 1'b0;
                    done_count++;
                end
                after_ack = 1'b1;
            end
            send_prev = bus.send;
        end
    end

    initial begin
        int c;
        bus.req = '0; bus.req_data = '0; bus.req_parity = '0; bus.req_baud = '0;
        bus.tx_active_flag = 1'b0; bus.tx_done_flag = 1'b0;
        model_en = 1'b1; model_abort = 1'b0;
        uart_act_delay = 1; uart_frame_len = 1;

        repeat (3) @(negedge clock);
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_nack", bus.nack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_send", bus.send, 0);
        check("rst_data_in", bus.data_in, 0);
        check("rst_parity", bus.parity_type, 0);
        check("rst_baud", bus.baud_rate, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // All four requesting with an instant UART: order 0,1,2,3,0.
        add_job(0, 8'h10, 2'b00, 2'b11, 0);
        add_job(0, 8'h14, 2'b01, 2'b00, 0);
        add_job(1, 8'h11, 2'b10, 2'b01, 0);
        add_job(2, 8'h12, 2'b11, 2'b10, 0);
        add_job(3, 8'h13, 2'b01, 2'b11, 0);
        schedule();
        wait_all(200);

        // Single slow frame at 9600 baud.
        uart_act_delay = 3; uart_frame_len = 57292;
        add_job(0, 8'hAA, 2'b01, 2'b10, 0);
        schedule();
        wait_all(60000);

        // Requester 1's inputs are rewritten while it holds the grant.
        uart_act_delay = 2; uart_frame_len = 30;
        add_job(1, 8'h5C, 2'b10, 2'b01, 0);
        schedule();
        wait_all(500);

        repeat (10) begin
            uart_act_delay = $urandom_range(1, 5);
            uart_frame_len = $urandom_range(1, 20);
            for (int i = 0; i < N; i++) begin
                int cnt = $urandom_range(0, 3);
                for (int k = 0; k < cnt; k++)
                    add_job(i, 8'($urandom), 2'($urandom), 2'($urandom), 0);
            end
            schedule();
            wait_all(2000);
        end

        // Reset during WAIT_DONE.
        uart_act_delay = 1; uart_frame_len = 400;
        add_job(1, 8'hC3, 2'b11, 2'b01, 0);
        schedule();
        c = 0;
        while (!bus.tx_active_flag && c < 50) begin
            @(negedge clock);
            c++;
        end
        check("reached_wait_done", bus.tx_active_flag, 1);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        model_abort = 1'b1;
        #1;
        check("arst_grant", bus.grant, 0);
        check("arst_ack", bus.ack, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_send", bus.send, 0);
        check("arst_data_in", bus.data_in, 0);
        check("arst_parity", bus.parity_type, 0);
        check("arst_baud", bus.baud_rate, 0);
        for (int i = 0; i < N; i++) job_q[i].delete();
        exp_q.delete();
        expected_done = done_count;
        ref_last = N - 1;
        bus.req = '0;
        bus.tx_active_flag = 1'b0;
        bus.tx_done_flag = 1'b0;
        repeat (4) @(negedge clock);
        model_abort = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Pointer back at NUM_REQ-1: requester 1 beats 2, then 2 alone.
        uart_act_delay = 2; uart_frame_len = 5;
        add_job(1, 8'h21, 2'b01, 2'b01, 0);
        add_job(2, 8'h22, 2'b10, 2'b10, 0);
        schedule();
        wait_all(300);
        add_job(2, 8'h42, 2'b00, 2'b11, 0);
        schedule();
        wait_all(300);

`ifdef UART_ARB_TIMEOUT_EN
        // Silent UART: the frame must end in nack.
        model_en = 1'b0;
        add_job(3, 8'h77, 2'b01, 2'b00, 1);
        schedule();
        wait_all(400);
        check("tmo_no_active", bus.tx_active_flag, 0);
        model_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
